// File: rtl/full_adder.sv
// One-bit full adder with an optional registered copy of its result and a carry-event counter.
// Build option: define FULL_ADDER_STATS_EN to include the saturating carry counter (carry_cnt is 0 otherwise).
module full_adder #(
    parameter int CNT_W = 8
) (
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             s,
    output logic             c_out,
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    output logic             s_q,
    output logic             c_out_q,
    output logic             vld_q,
    output logic [CNT_W-1:0] carry_cnt
);

    // Combinational path ignores clk/rst/vld_in and passes X/Z straight through.
    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (a & c) | (b & c);

    // Handshake: vld_in alone qualifies a capture (no ready/backpressure);
    // vld_q is vld_in delayed one cycle and is never gated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            c_out_q <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= vld_in;
            if (vld_in) begin
                s_q     <= s;
                c_out_q <= c_out;
            end
        end
    end

`ifdef FULL_ADDER_STATS_EN
    // Counts captured operations that produced a carry; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (vld_in && c_out && (carry_cnt != {CNT_W{1'b1}})) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: vector table, directed reset/capture/saturation
// sequences, then randomized traffic against an arithmetic reference model.
module tb_full_adder;

    logic       clk;
    logic       rst;
    logic       a, b, c;
    logic       vld_in;
    logic       s, c_out, s_q, c_out_q, vld_q;
    logic [7:0] carry_cnt;
    logic       s2, c_out2, s_q2, c_out_q2, vld_q2;
    logic [1:0] carry_cnt2;

    int total = 0;
    int bad   = 0;

`ifdef FULL_ADDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    full_adder #(.CNT_W(8)) dut (
        .a(a), .b(b), .c(c), .s(s), .c_out(c_out),
        .clk(clk), .rst(rst), .vld_in(vld_in),
        .s_q(s_q), .c_out_q(c_out_q), .vld_q(vld_q), .carry_cnt(carry_cnt)
    );

    full_adder #(.CNT_W(2)) dut2 (
        .a(a), .b(b), .c(c), .s(s2), .c_out(c_out2),
        .clk(clk), .rst(rst), .vld_in(vld_in),
        .s_q(s_q2), .c_out_q(c_out_q2), .vld_q(vld_q2), .carry_cnt(carry_cnt2)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_s_q"},     32'(s_q),        32'd0);
        check({tag, "_c_out_q"}, 32'(c_out_q),    32'd0);
        check({tag, "_vld_q"},   32'(vld_q),      32'd0);
        check({tag, "_cnt"},     32'(carry_cnt),  32'd0);
        check({tag, "_cnt2"},    32'(carry_cnt2), 32'd0);
    endtask

    task automatic drive(input logic [2:0] abc, input logic v);
        {a, b, c} = abc;
        vld_in    = v;
    endtask

    // Scoreboard: packed {s_q, c_out_q, vld_q, cnt8[7:0], cnt2[1:0]}
    localparam int W = 13;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [2:0] abc;
        logic       s;
        logic       co;
    } vec_t;

    vec_t vecs[8];
    int   sat_seq[5];

    initial begin
        int m_sq, m_cq, m_vq, m_cnt, m_cnt2, sum;
        logic [W-1:0] e;

        vecs[0] = '{3'b000, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 1'b1, 1'b0};
        vecs[2] = '{3'b010, 1'b1, 1'b0};
        vecs[3] = '{3'b011, 1'b0, 1'b1};
        vecs[4] = '{3'b100, 1'b1, 1'b0};
        vecs[5] = '{3'b101, 1'b0, 1'b1};
        vecs[6] = '{3'b110, 1'b0, 1'b1};
        vecs[7] = '{3'b111, 1'b1, 1'b1};
        sat_seq = '{1, 2, 3, 3, 3};

        rst = 1'b1;
        drive(3'b000, 1'b0);

        // Combinational sweep, held in reset so only the adder path matters
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = vecs[i].abc;
            #1;
            check($sformatf("sweep_s_%b", vecs[i].abc),  32'(s),      32'(vecs[i].s));
            check($sformatf("sweep_co_%b", vecs[i].abc), 32'(c_out),  32'(vecs[i].co));
            check($sformatf("sweep_s2_%b", vecs[i].abc), 32'(s2),     32'(vecs[i].s));
        end

        // Reset held while clocking with captures requested
        drive(3'b111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_s",  32'(s),     32'd1);
            check("rst_hold_co", 32'(c_out), 32'd1);
            check_regs_zero("rst_hold");
        end

        // First capture after release, then hold with vld_in low
        @(negedge clk);
        rst = 1'b0;
        drive(3'b011, 1'b1);
        @(posedge clk); #1;
        check("cap_s_q",   32'(s_q),        32'd0);
        check("cap_co_q",  32'(c_out_q),    32'd1);
        check("cap_vld_q", 32'(vld_q),      32'd1);
        check("cap_cnt",   32'(carry_cnt),  STATS ? 32'd1 : 32'd0);
        check("cap_cnt2",  32'(carry_cnt2), STATS ? 32'd1 : 32'd0);
        @(negedge clk);
        drive(3'b100, 1'b0);
        @(posedge clk); #1;
        check("hold_s",    32'(s),          32'd1);
        check("hold_co",   32'(c_out),      32'd0);
        check("hold_s_q",  32'(s_q),        32'd0);
        check("hold_co_q", 32'(c_out_q),    32'd1);
        check("hold_vld_q", 32'(vld_q),     32'd0);
        check("hold_cnt",  32'(carry_cnt),  STATS ? 32'd1 : 32'd0);

        // Saturation of the 2-bit counter
        @(negedge clk);
        rst = 1'b1; #1;
        check("async_clr_cnt2", 32'(carry_cnt2), 32'd0);
        rst = 1'b0;
        drive(3'b111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("sat_cnt2_%0d", i), 32'(carry_cnt2), STATS ? 32'(sat_seq[i]) : 32'd0);
            check($sformatf("sat_cnt8_%0d", i), 32'(carry_cnt),  STATS ? 32'(i + 1) : 32'd0);
        end

        // Asynchronous reset between edges with a count of 2 outstanding
        @(negedge clk);
        rst = 1'b1; #1;
        rst = 1'b0;
        drive(3'b111, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_async_cnt", 32'(carry_cnt), STATS ? 32'd2 : 32'd0);
        check("pre_async_vld", 32'(vld_q),     32'd1);
        #2;
        rst = 1'b1; #1;
        check_regs_zero("async_mid");
        @(posedge clk); #1;
        check_regs_zero("async_inflight");
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 1'b0);

        // Randomized traffic against the arithmetic model
        m_sq = 0; m_cq = 0; m_vq = 0; m_cnt = 0; m_cnt2 = 0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; #1;
                rst = 1'b0;
                m_sq = 0; m_cq = 0; m_vq = 0; m_cnt = 0; m_cnt2 = 0;
            end
            a      = 1'($urandom_range(0, 1));
            b      = 1'($urandom_range(0, 1));
            c      = 1'($urandom_range(0, 1));
            vld_in = ($urandom_range(0, 3) != 0);
            #1;
            sum = int'(a) + int'(b) + int'(c);
            check("rnd_s",  32'(s),     32'(sum % 2));
            check("rnd_co", 32'(c_out), 32'(sum >= 2));

            m_vq = int'(vld_in);
            if (vld_in) begin
                m_sq = sum % 2;
                m_cq = (sum >= 2) ? 1 : 0;
                if (sum >= 2) begin
                    m_cnt  = (m_cnt  + 1 > 255) ? 255 : m_cnt + 1;
                    m_cnt2 = (m_cnt2 + 1 > 3)   ? 3   : m_cnt2 + 1;
                end
            end
            exp_q.push_back({1'(m_sq), 1'(m_cq), 1'(m_vq),
                             STATS ? 8'(m_cnt) : 8'd0, STATS ? 2'(m_cnt2) : 2'd0});

            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                check("rnd_queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rnd_s_q",   32'(s_q),        32'(e[12]));
                check("rnd_co_q",  32'(c_out_q),    32'(e[11]));
                check("rnd_vld_q", 32'(vld_q),      32'(e[10]));
                check("rnd_cnt",   32'(carry_cnt),  32'(e[9:2]));
                check("rnd_cnt2",  32'(carry_cnt2), 32'(e[1:0]));
            end
        end

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
